adain_out_stream: RTL and testbench

Output stage directly downstream of the AdaIN normalisation datapath. Accepts the normalised pixel stream (one pixel per cycle, qualified by the AdaIN `out_en` strobe), optionally applies a leaky ReLU, and buffers it in a small FIFO. It presents the pixels as an AXI4-Stream master with `tlast` marking the final pixel of each N×N channel. The AdaIN datapath cannot stall, so the block raises an almost-full `stall` to the upstream sequencer and flags any overflow.

---
 rtl/adain_pkg.sv | 16 +
 rtl/adain_sync_fifo.sv | 53 +++++
 rtl/adain_out_stream.sv | 164 ++++++++++++++++
 tb/tb_adain_out_stream.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/adain_pkg.sv
// Shared types and constants for the AdaIN output stream block.
package adain_pkg;

  typedef enum logic {
    FR_IDLE   = 1'b0,
    FR_ACTIVE = 1'b1
  } frame_state_e;

  localparam int unsigned ADAIN_DATA_W = 16;

  // Leaky ReLU negative slope ~0.203 = 2^-3 + 2^-4 + 2^-6
  localparam int unsigned LRELU_SH_A = 3;
  localparam int unsigned LRELU_SH_B = 4;
  localparam int unsigned LRELU_SH_C = 6;

endpackage : adain_pkg

// File: rtl/adain_sync_fifo.sv
// Synchronous first-word fall-through FIFO; head entry is always visible on rdata.
module adain_sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is not reset; the consumer qualifies the head with count != 0.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));

endmodule : adain_sync_fifo

// File: rtl/adain_out_stream.sv
// AdaIN output stage: optional leaky ReLU, FIFO buffering, AXI4-Stream master with per-channel tlast.
// Optional feature: define ADAIN_OUT_LRELU_EN to enable the leaky ReLU on negative pixels.
module adain_out_stream
  import adain_pkg::*;
#(
  parameter int unsigned DATA_W     = ADAIN_DATA_W,
  parameter int unsigned N_MAX      = 128,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(N_MAX+1)-1:0]   N,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic [DATA_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         stall,
  output logic                         overflow,
  input  logic                         clr_ovf,
  output logic                         busy
);

  localparam int unsigned NW       = $clog2(N_MAX+1);
  localparam int unsigned PW       = $clog2(N_MAX*N_MAX+1);
  localparam int unsigned CW       = $clog2(FIFO_DEPTH+1);
  localparam int unsigned EW       = DATA_W + 1;
  localparam int unsigned AF_LEVEL = FIFO_DEPTH - AF_MARGIN;

  frame_state_e      state_q, state_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [PW-1:0]     total_q, total_d;
  logic [NW-1:0]     n_eff_c;
  logic [PW-1:0]     total_new_c;
  logic              last_c;

  logic [DATA_W-1:0] pix_c;
  logic              fifo_wr_c;
  logic              fifo_rd_c;
  logic              drop_c;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic [EW-1:0]     fifo_head;
  logic [CW-1:0]     count_nxt_c;

  // Frame size seen by the first pixel of a frame; N==0 is treated as 1.
  always_comb begin
    n_eff_c     = (N == '0) ? NW'(1) : N;
    total_new_c = PW'(n_eff_c) * PW'(n_eff_c);
  end

  // Frame FSM: next state, pixel counter and last tag for the incoming pixel.
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    total_d   = total_q;
    last_c    = 1'b0;
    case (state_q)
      FR_IDLE: begin
        if (in_valid) begin
          total_d = total_new_c;
          if (total_new_c == PW'(1)) begin
            last_c    = 1'b1;
            pix_cnt_d = '0;
          end else begin
            state_d   = FR_ACTIVE;
            pix_cnt_d = PW'(1);
          end
        end
      end
      FR_ACTIVE: begin
        if (in_valid) begin
          if (pix_cnt_q == total_q - PW'(1)) begin
            last_c    = 1'b1;
            pix_cnt_d = '0;
            state_d   = FR_IDLE;
          end else begin
            pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end
      end
      default: begin
        state_d   = FR_IDLE;
        pix_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FR_IDLE;
      pix_cnt_q <= '0;
      total_q   <= PW'(1);
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      total_q   <= total_d;
    end
  end

`ifdef ADAIN_OUT_LRELU_EN
  logic signed [DATA_W-1:0] x_c;
  assign x_c = $signed(in_data);

  // Arithmetic shifts floor each term, so small negatives round away from zero.
  always_comb begin
    pix_c = in_data;
    if (x_c[DATA_W-1]) begin
      pix_c = DATA_W'((x_c >>> LRELU_SH_A) + (x_c >>> LRELU_SH_B) + (x_c >>> LRELU_SH_C));
    end
  end
`else
  assign pix_c = in_data;
`endif

  // A read frees the head slot, so a write is still accepted when full.
  always_comb begin
    fifo_rd_c = m_axis_tvalid & m_axis_tready;
    fifo_wr_c = in_valid & (~fifo_full | fifo_rd_c);
    drop_c    = in_valid & fifo_full & ~fifo_rd_c;
    case ({fifo_wr_c, fifo_rd_c})
      2'b10:   count_nxt_c = fifo_count + CW'(1);
      2'b01:   count_nxt_c = fifo_count - CW'(1);
      default: count_nxt_c = fifo_count;
    endcase
  end

  adain_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (fifo_wr_c),
    .wdata ({last_c, pix_c}),
    .rd    (fifo_rd_c),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Almost-full and sticky overflow flags; a new drop wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      stall <= (count_nxt_c >= CW'(AF_LEVEL));
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_head[DATA_W-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & fifo_head[DATA_W];
  assign busy          = (state_q == FR_ACTIVE) | m_axis_tvalid;

endmodule : adain_out_stream

// File: tb/tb_adain_out_stream.sv
// Directed self-checking bench for adain_out_stream (default parameters).
`timescale 1ns/1ps
module tb_adain_out_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  N;
  logic        in_valid;
  logic [15:0] in_data;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        stall;
  logic        overflow;
  logic        clr_ovf;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int beat_d[$];
  bit beat_l[$];
  int exp_d[$];
  bit exp_l[$];

  always #5 clk = ~clk;

  adain_out_stream dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .N             (N),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .stall         (stall),
    .overflow      (overflow),
    .clr_ovf       (clr_ovf),
    .busy          (busy)
  );

  // Record every accepted output beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      beat_d.push_back(int'($signed(m_axis_tdata)));
      beat_l.push_back(m_axis_tlast);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit v, input int d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = 16'(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic compare_beats(input string tag);
    check($sformatf("%s_nbeats", tag), beat_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < beat_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), beat_d[i], exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), int'(beat_l[i]), int'(exp_l[i]));
    end
  endtask

  task automatic clear_logs();
    beat_d.delete();
    beat_l.delete();
    exp_d.delete();
    exp_l.delete();
  endtask

  initial begin
    rst_n         = 1'b0;
    N             = 8'd4;
    in_valid      = 1'b0;
    in_data       = '0;
    m_axis_tready = 1'b1;
    clr_ovf       = 1'b0;

    #12;
    check("rst_tvalid", int'(m_axis_tvalid), 0);
    check("rst_tdata", int'(m_axis_tdata), 0);
    check("rst_tlast", int'(m_axis_tlast), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // N=4 single frame, tready high
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i);
      exp_d.push_back(i);
      exp_l.push_back(i == 15);
    end
    step(1'b0, 0);
    check("t1_busy_last_beat", int'(busy), 1);
    check("t1_tlast_on_15", int'(m_axis_tlast), 1);
    step(1'b0, 0);
    check("t1_busy_after", int'(busy), 0);
    check("t1_tvalid_after", int'(m_axis_tvalid), 0);
    compare_beats("t1");

    // N=2 two back-to-back frames
    clear_logs();
    N = 8'd2;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 100 + i);
      exp_d.push_back(100 + i);
      exp_l.push_back(i == 3 || i == 7);
    end
    idle(3);
    check("t2_busy", int'(busy), 0);
    compare_beats("t2");

    // Fill with tready low: stall threshold, then overflow
    clear_logs();
    N = 8'd4;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b1, i);
    check("t3_stall_at_11", int'(stall), 0);
    step(1'b0, 0);
    check("t3_stall_at_12", int'(stall), 1);
    check("t3_ovf_at_12", int'(overflow), 0);
    for (int i = 12; i < 17; i++) step(1'b1, i);
    step(1'b0, 0);
    check("t3_ovf_set", int'(overflow), 1);
    check("t3_tvalid_full", int'(m_axis_tvalid), 1);
    check("t3_head_hold", int'(m_axis_tdata), 0);
    clr_ovf = 1'b1;
    step(1'b0, 0);
    clr_ovf = 1'b0;
    check("t3_ovf_clr", int'(overflow), 0);

    // Full FIFO with simultaneous read and write
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    in_valid      = 1'b1;
    in_data       = 16'd555;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    m_axis_tready = 1'b0;
    check("t4_no_ovf", int'(overflow), 0);
    check("t4_stall_full", int'(stall), 1);
    check("t4_new_head", int'(m_axis_tdata), 1);
    m_axis_tready = 1'b1;
    idle(20);
    for (int i = 0; i < 16; i++) begin
      exp_d.push_back(i);
      exp_l.push_back(i == 15);
    end
    exp_d.push_back(555);
    exp_l.push_back(1'b0);
    compare_beats("t4");
    check("t4_busy_midframe", int'(busy), 1);

    // Leaky ReLU (or pass-through)
    clear_logs();
    step(1'b1, -64);
    step(1'b1, 100);
    step(1'b1, -1);
    idle(3);
`ifdef ADAIN_OUT_LRELU_EN
    exp_d.push_back(-13);
    exp_d.push_back(100);
    exp_d.push_back(-3);
`else
    exp_d.push_back(-64);
    exp_d.push_back(100);
    exp_d.push_back(-1);
`endif
    for (int i = 0; i < 3; i++) exp_l.push_back(1'b0);
    compare_beats("t5");

    // Reset mid-frame discards FIFO and frame
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, i);
    step(1'b0, 0);
    check("t6_tvalid_pre", int'(m_axis_tvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_tvalid", int'(m_axis_tvalid), 0);
    check("t6_tdata", int'(m_axis_tdata), 0);
    check("t6_tlast", int'(m_axis_tlast), 0);
    check("t6_stall", int'(stall), 0);
    check("t6_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 200 + i);
      exp_d.push_back(200 + i);
      exp_l.push_back(i == 15);
    end
    idle(3);
    compare_beats("t6");

    // N=0 behaves as 1x1: every pixel is last
    clear_logs();
    N = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 7 + i);
      exp_d.push_back(7 + i);
      exp_l.push_back(1'b1);
    end
    idle(3);
    compare_beats("t7");
    check("t7_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_adain_out_stream
